// File: rtl/lane_traffic_engine.sv
// Multi-lane horizontal traffic engine: per-lane step timers, wrapping car positions
// and a registered player/car overlap flag.
module lane_traffic_engine #(
  parameter int NUM_LANES      = 4,
  parameter int H_DISPLAY      = 640,
  parameter int STEP           = 32,
  parameter int CAR_W          = 32,
  parameter int LANE_Y0        = 288,
  parameter int LANE_PITCH     = 32,
  parameter int PERIOD_W       = 32,
  parameter int DEFAULT_PERIOD = 2500000,
  localparam int LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    enable,
  input  logic                    cfg_we,
  input  logic [LW-1:0]           cfg_lane,
  input  logic [PERIOD_W-1:0]     cfg_period,
  input  logic                    cfg_dir,
  input  logic [9:0]              player_x,
  input  logic [9:0]              player_y,
  output logic [NUM_LANES*10-1:0] car_x,
  output logic [NUM_LANES*10-1:0] car_y,
  output logic [NUM_LANES-1:0]    step_pulse,
  output logic                    collision
);

  localparam logic [11:0] H_W     = 12'(H_DISPLAY);
  localparam logic [11:0] STEP_W  = 12'(STEP);
  localparam logic [11:0] CAR_W_W = 12'(CAR_W);
  localparam logic [11:0] HI_W    = 12'(H_DISPLAY - CAR_W);
  localparam logic [PERIOD_W-1:0] PER_ONE = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] DEF_PER = PERIOD_W'(DEFAULT_PERIOD);

  logic [NUM_LANES-1:0] hit;

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      logic [PERIOD_W-1:0] cnt_q;
      logic [PERIOD_W-1:0] period_q;
      logic                dir_q;
      logic [9:0]          x_q;
      logic                pulse_q;
      logic                sel;
      logic                at_tc;
      logic                step;
      logic [11:0]         x_ext;
      logic [11:0]         x_fwd;
      logic [11:0]         x_back;
      logic [9:0]          x_next;
      logic [11:0]         d_sum;
      logic [11:0]         d;
      logic [9:0]          lane_y;

      assign lane_y = 10'(LANE_Y0 + i * LANE_PITCH);
      assign sel    = cfg_we && (cfg_lane == LW'(i));
      assign at_tc  = (period_q != '0) && (cnt_q >= period_q - PER_ONE);
      // A config write to this lane pre-empts a coincident step.
      assign step   = enable && at_tc && !sel;

      assign x_ext  = {2'b00, x_q};
      assign x_fwd  = x_ext + STEP_W;
      assign x_back = x_ext + H_W - STEP_W;
      assign x_next = dir_q ? 10'((x_ext < STEP_W) ? x_back : (x_ext - STEP_W))
                            : 10'((x_fwd >= H_W) ? (x_fwd - H_W) : x_fwd);

      // Circular distance so cars straddling the wrap edge still collide.
      assign d_sum  = {2'b00, player_x} + H_W - x_ext;
      assign d      = d_sum % H_W;
      assign hit[i] = (player_y == lane_y) && ((d < CAR_W_W) || (d > HI_W));

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          cnt_q    <= '0;
          period_q <= DEF_PER;
          dir_q    <= 1'(i % 2);
          x_q      <= '0;
          pulse_q  <= 1'b0;
        end else begin
          pulse_q <= step;
          if (sel) begin
            period_q <= cfg_period;
            dir_q    <= cfg_dir;
            cnt_q    <= '0;
          end else if (enable) begin
            if ((period_q == '0) || at_tc) cnt_q <= '0;
            else                           cnt_q <= cnt_q + PER_ONE;
            if (step) x_q <= x_next;
          end
        end
      end

      assign car_x[10*i +: 10] = x_q;
      assign car_y[10*i +: 10] = lane_y;
      assign step_pulse[i]     = pulse_q;
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) collision <= 1'b0;
    else        collision <= |hit;
  end

endmodule
